// File: rtl/ame_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ame_norm_pkg
// Description : Shared types and default sizing for the normalizer arbiter:
//               control state encoding, tag pipeline entry and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package ame_norm_pkg;

  localparam int unsigned DEF_COMP_DATA_BITS = 64;
  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_NORM_LAT       = 2;
  localparam int unsigned DEF_RSP_DEPTH      = 4;

  // Tag id field is sized for the largest supported requester count (256).
  localparam int unsigned TAG_ID_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic [TAG_ID_BITS-1:0] id;
  } tag_t;

endpackage : ame_norm_pkg
`default_nettype wire

// File: rtl/ame_norm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ame_norm_fifo
// Description : First-word fall-through result FIFO. Push and pop may happen
//               together at any occupancy, including full. Read data is
//               forced to zero while empty so nothing stale leaks out.
// Revision    : 1.0 - initial release
// ============================================================================
module ame_norm_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Handshake qualification and pointer/count next-state
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Fall-through read port
  always_comb begin
    empty_o    = (count_q == '0);
    count_o    = count_q;
    pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule : ame_norm_fifo
`default_nettype wire

// File: rtl/ame_norm_arb.sv
`default_nettype none
// ============================================================================
// Module      : ame_norm_arb
// Description : Round-robin arbiter sharing one fixed-latency normalizer
//               between several requesters. A tag pipeline tracks which
//               requester owns each normalizer slot; results are collected
//               into a credit-protected FIFO and returned in grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module ame_norm_arb
  import ame_norm_pkg::*;
#(
  parameter  int unsigned COMP_DATA_BITS = DEF_COMP_DATA_BITS,
  parameter  int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter  int unsigned NORM_LAT       = DEF_NORM_LAT,
  parameter  int unsigned RSP_DEPTH      = DEF_RSP_DEPTH,
  localparam int unsigned SHIFT_W        = $clog2(COMP_DATA_BITS),
  localparam int unsigned ID_W           = $clog2(NUM_REQ),
  localparam int unsigned CNT_W          = $clog2(RSP_DEPTH) + 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    enable_i,
  output logic                                    busy_o,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ-1:0][COMP_DATA_BITS-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0][SHIFT_W-1:0]         req_shift_i,
  output logic                                    norm_init_o,
  output logic [SHIFT_W-1:0]                      norm_shift_o,
  output logic [COMP_DATA_BITS-1:0]               norm_data_o,
  input  logic                                    norm_done_i,
  input  logic [COMP_DATA_BITS-1:0]               norm_data_i,
  output logic                                    rsp_valid_o,
  input  logic                                    rsp_ready_i,
  output logic [ID_W-1:0]                         rsp_id_o,
  output logic [COMP_DATA_BITS-1:0]               rsp_data_o
);

  localparam int unsigned FIFO_W = ID_W + COMP_DATA_BITS;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              err_q, err_d;
  tag_t              tag_q [NORM_LAT];
  tag_t              tag_d [NORM_LAT];

  logic              run;
  logic              credit_ok;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand_idx;
  logic              xfer;
  tag_t              head;
  logic              head_exit;
  logic              push;
  logic [FIFO_W-1:0] pop_data;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              unused_head_id;

  // State register plus all other control flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      inflight_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NORM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      tag_q      <= tag_d;
    end
  end

  // Next-state: DRAIN waits for the normalizer pipeline to empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_RUN;
      ST_RUN:   if (!enable_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end else if (inflight_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; a sticky error keeps busy asserted until reset
  always_comb begin
    run         = (state_q == ST_RUN);
    norm_init_o = (state_q != ST_IDLE);
    busy_o      = (state_q != ST_IDLE) | err_q;
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Grant gated by state and by FIFO credit covering every in-flight result
  always_comb begin
    credit_ok   = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(RSP_DEPTH);
    req_ready_o = '0;
    if (run && credit_ok && grant_found) begin
      req_ready_o[grant_idx] = 1'b1;
    end
    xfer         = |(req_valid_i & req_ready_o);
    norm_data_o  = xfer ? req_data_i[grant_idx]  : '0;
    norm_shift_o = xfer ? req_shift_i[grant_idx] : '0;
    rr_ptr_d     = xfer ? grant_idx : rr_ptr_q;
  end

  // Tag pipeline mirrors the normalizer latency; head meets norm_done_i
  always_comb begin
    tag_d = tag_q;
    if (norm_init_o) begin
      tag_d[0].valid = xfer;
      tag_d[0].id    = xfer ? TAG_ID_BITS'(grant_idx) : '0;
      for (int i = 1; i < NORM_LAT; i++) begin
        tag_d[i] = tag_q[i - 1];
      end
    end
  end

  // Head retirement: push on matching done, flag error on a missing one
  always_comb begin
    head       = tag_q[NORM_LAT - 1];
    head_exit  = norm_init_o & head.valid;
    push       = head_exit & norm_done_i;
    err_d      = err_q | (head_exit & ~norm_done_i);
    inflight_d = inflight_q;
    if (xfer && !head_exit) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!xfer && head_exit) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // Upper tag id bits exist only to support larger requester counts
  assign unused_head_id = ^head.id;

  ame_norm_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i ({head.id[ID_W-1:0], norm_data_i}),
    .pop_i       (rsp_ready_i),
    .pop_data_o  (pop_data),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  // Result stream view of the FIFO head
  always_comb begin
    rsp_valid_o = ~fifo_empty;
    rsp_id_o    = pop_data[FIFO_W-1 -: ID_W];
    rsp_data_o  = pop_data[COMP_DATA_BITS-1:0];
  end

endmodule : ame_norm_arb
`default_nettype wire

// File: tb/tb_ame_norm_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ame_norm_arb
// Description : Directed self-checking bench for ame_norm_arb with a
//               fixed-latency normalizer model returning data << shift.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ame_norm_arb;

  localparam int unsigned DW  = 64;
  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 4;
  localparam int unsigned SW  = $clog2(DW);
  localparam int unsigned IW  = $clog2(NR);

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    enable = 1'b0;
  logic                    busy;
  logic [NR-1:0]           req_valid = '0;
  logic [NR-1:0]           req_ready;
  logic [NR-1:0][DW-1:0]   req_data = '0;
  logic [NR-1:0][SW-1:0]   req_shift = '0;
  logic                    norm_init;
  logic [SW-1:0]           norm_shift;
  logic [DW-1:0]           norm_data;
  logic                    norm_done;
  logic [DW-1:0]           norm_res;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b0;
  logic [IW-1:0]           rsp_id;
  logic [DW-1:0]           rsp_data;
  logic                    suppress = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [LAT-1:0] m_done;
  logic [DW-1:0]  m_data [LAT];

  always #5 clk = ~clk;

  // Normalizer model: LAT register stages, done flags every init cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= '0;
      for (int i = 0; i < LAT; i++) m_data[i] <= '0;
    end else begin
      m_done[0] <= norm_init;
      m_data[0] <= norm_data << norm_shift;
      for (int i = 1; i < LAT; i++) begin
        m_done[i] <= m_done[i-1];
        m_data[i] <= m_data[i-1];
      end
    end
  end

  assign norm_done = m_done[LAT-1] & ~suppress;
  assign norm_res  = m_data[LAT-1];

  ame_norm_arb #(
    .COMP_DATA_BITS (DW),
    .NUM_REQ        (NR),
    .NORM_LAT       (LAT),
    .RSP_DEPTH      (DEP)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .busy_o       (busy),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_shift_i  (req_shift),
    .norm_init_o  (norm_init),
    .norm_shift_o (norm_shift),
    .norm_data_o  (norm_data),
    .norm_done_i  (norm_done),
    .norm_data_i  (norm_res),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; req_valid = '0; rsp_ready = 1'b0; suppress = 1'b0;
    req_data = '0; req_shift = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_run();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    req_valid = 4'hF; enable = 1'b1; rsp_ready = 1'b1;
    req_data[0] = 64'h55; req_shift[0] = 6'd3;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (norm_init !== 1'b0) begin errors++; $display("FAIL reset_init got %b exp 0", norm_init); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 64'h0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_data got %h/%h exp 0/0", rsp_id, rsp_data); end
    checks++; if (norm_data !== 64'h0 || norm_shift !== 6'd0) begin errors++; $display("FAIL reset_norm_out got %h/%h exp 0/0", norm_data, norm_shift); end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    start_run();
    req_valid = 4'b0001; req_data[0] = 64'h1; req_shift[0] = 6'd4;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    checks++; if (norm_data !== 64'h1 || norm_shift !== 6'd4) begin errors++; $display("FAIL single_mux got %h/%0d exp 1/4", norm_data, norm_shift); end
    checks++; if (norm_init !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_run got init %b busy %b exp 1 1", norm_init, busy); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (norm_data !== 64'h0) begin errors++; $display("FAIL single_idle_mux got %h exp 0", norm_data); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 got %b exp 0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_lat2 got %b exp 0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'h10) begin
      errors++; $display("FAIL single_rsp got v%b id%0d %h exp v1 id0 10", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_rr [4];
    logic [NR-1:0] exp_rdy;
    int rsp_n;
    exp_rr = '{64'd1, 64'd4, 64'd12, 64'd32};
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      req_data[k] = DW'(k + 1); req_shift[k] = SW'(k);
    end
    start_run();
    rsp_n = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid = (i < 8) ? 4'hF : 4'h0;
      #1;
      if (i < 8) begin
        exp_rdy = 4'b0001 << (i % 4);
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant cyc %0d got %b exp %b", i, req_ready, exp_rdy); end
      end
      if (rsp_valid === 1'b1) begin
        checks++; if (rsp_id !== IW'(rsp_n % 4) || rsp_data !== exp_rr[rsp_n % 4]) begin
          errors++; $display("FAIL rr_rsp %0d got id%0d %h exp id%0d %h", rsp_n, rsp_id, rsp_data, rsp_n % 4, exp_rr[rsp_n % 4]); end
        rsp_n++;
      end
      @(negedge clk);
    end
    checks++; if (rsp_n != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", rsp_n); end
  endtask

  task automatic test_backpressure();
    int gnt;
    do_reset();
    for (int k = 0; k < NR; k++) begin
      req_data[k] = DW'(k + 1); req_shift[k] = SW'(k);
    end
    start_run();
    gnt = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 4'hF; #1;
      if (req_ready !== 4'h0) gnt++;
      @(negedge clk);
    end
    #1;
    checks++; if (gnt != 4) begin errors++; $display("FAIL bp_grants got %0d exp 4", gnt); end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'd1) begin
      errors++; $display("FAIL bp_head got v%b id%0d %h exp v1 id0 1", rsp_valid, rsp_id, rsp_data); end
    rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL bp_full_ready got %b exp 0000", req_ready); end
    @(negedge clk); rsp_ready = 1'b0; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_regrant got %b exp 0001", req_ready); end
    checks++; if (rsp_id !== 2'd1 || rsp_data !== 64'd4) begin errors++; $display("FAIL bp_next_head got id%0d %h exp id1 4", rsp_id, rsp_data); end
    gnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (req_ready !== 4'h0) gnt++;
    end
    checks++; if (gnt != 0) begin errors++; $display("FAIL bp_no_more got %0d exp 0", gnt); end
  endtask

  task automatic test_drain();
    do_reset();
    rsp_ready = 1'b1;
    req_data[0] = 64'd1; req_shift[0] = 6'd4;
    req_data[1] = 64'd3; req_shift[1] = 6'd1;
    start_run();
    req_valid = 4'b0011; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drain_g0 got %b exp 0001", req_ready); end
    @(negedge clk); enable = 1'b0; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL drain_g1 got %b exp 0010", req_ready); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1 || norm_init !== 1'b1 || req_ready !== 4'h0) begin
      errors++; $display("FAIL drain_state got busy%b init%b rdy%b exp 1 1 0000", busy, norm_init, req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'h10) begin
      errors++; $display("FAIL drain_rsp0 got v%b id%0d %h exp v1 id0 10", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 64'h6 || busy !== 1'b1) begin
      errors++; $display("FAIL drain_rsp1 got v%b id%0d %h busy%b exp v1 id1 6 busy1", rsp_valid, rsp_id, rsp_data, busy); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || norm_init !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'h0) begin
      errors++; $display("FAIL drain_idle got busy%b init%b v%b rdy%b exp 0 0 0 0000", busy, norm_init, rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    req_data[0] = 64'd5; req_shift[0] = 6'd0;
    start_run();
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0001;
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered got %b exp 1", rsp_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || norm_init !== 1'b0) begin
      errors++; $display("FAIL rmid_async got v%b busy%b init%b exp 0 0 0", rsp_valid, busy, norm_init); end
    @(negedge clk);
    rst = 1'b0; enable = 1'b0; rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_emitted got %0d exp 0", seen); end
  endtask

  task automatic test_err();
    do_reset();
    rsp_ready = 1'b1;
    req_shift[0] = 6'd0;
    start_run();
    for (int i = 0; i < 8; i++) begin
      req_valid   = (i < 3) ? 4'b0001 : 4'b0000;
      req_data[0] = DW'(i + 1);
      suppress    = (i == 3);
      #1;
      if (i < 3) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL err_grant cyc %0d got %b exp 0001", i, req_ready); end
      end
      if (i == 3) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd1) begin errors++; $display("FAIL err_rsp0 got v%b %h exp v1 1", rsp_valid, rsp_data); end
      end
      if (i == 4) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_dropped got %b exp 0", rsp_valid); end
      end
      if (i == 5) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd3) begin errors++; $display("FAIL err_rsp2 got v%b %h exp v1 3", rsp_valid, rsp_data); end
      end
      if (i == 6) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_tail got %b exp 0", rsp_valid); end
      end
      @(negedge clk);
    end
    enable = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_sticky_busy got %b exp 1", busy); end
    checks++; if (norm_init !== 1'b0) begin errors++; $display("FAIL err_idle_init got %b exp 0", norm_init); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ame_norm_arb
`default_nettype wire

// File: doc/ame_norm_arb.md
AME_NORM_ARB -- requirements
Module: ame_norm_arb

Interface
REQ-001 Parameter COMP_DATA_BITS, default 64: width of operand and result data.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the normalizer.
REQ-003 Parameter NORM_LAT, default 2: fixed cycles from normalizer input sample to matching comp_done/result.
REQ-004 Parameter RSP_DEPTH, default 4: result FIFO entries, power of two.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous assert, active-high.
REQ-007 enable_i  in  1  run request; low requests drain then idle.
REQ-008 busy_o  out  1  high when the state is not IDLE.
REQ-009 req_valid_i  in  NUM_REQ  per-requester operand valid.
REQ-010 req_ready_o  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-011 req_data_i  in  NUM_REQ x COMP_DATA_BITS  operands.
REQ-012 req_shift_i  in  NUM_REQ x clog2(COMP_DATA_BITS)  per-operand shift amounts.
REQ-013 norm_init_o / norm_shift_o / norm_data_o  out  1 / clog2(COMP_DATA_BITS) / COMP_DATA_BITS  drive the normalizer comp_init/comp_shift/comp_data inputs.
REQ-014 norm_done_i / norm_data_i  in  1 / COMP_DATA_BITS  normalizer comp_done/comp_data outputs.
REQ-015 rsp_valid_o, rsp_ready_i, rsp_id_o (clog2(NUM_REQ)), rsp_data_o (COMP_DATA_BITS)  result stream, valid/ready handshake.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable_i=1; RUN->DRAIN when enable_i=0; DRAIN->IDLE when the in-flight pipeline is empty; DRAIN->RUN when enable_i=1 again.
REQ-017 norm_init_o SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-018 Grant only in RUN, round-robin: highest priority is the requester after the last granted one, index increasing with wrap NUM_REQ-1->0.
REQ-019 Grant requires credit: inflight_cnt + fifo_cnt < RSP_DEPTH; otherwise req_ready_o=0.
REQ-020 A transfer is req_valid_i[k] & req_ready_o[k]; on it norm_data_o/norm_shift_o = requester k operands in the same cycle (combinational mux); with no transfer they hold 0.
REQ-021 A NORM_LAT-deep tag pipeline of {valid, id} SHALL shift every cycle norm_init_o=1; the entry is valid only for a transfer.
REQ-022 When the pipeline head is valid and norm_done_i=1, {head id, norm_data_i} SHALL be pushed into the result FIFO; a done with an invalid head SHALL be discarded.
REQ-023 Result FIFO: first-word fall-through, rsp_valid_o = not empty; pop on rsp_valid_o & rsp_ready_i; simultaneous push and pop allowed at any occupancy, including full.
REQ-024 Results SHALL leave in grant order; latency from transfer to rsp_valid_o = NORM_LAT+1 cycles when the FIFO is empty.
REQ-025 inflight_cnt increments on transfer, decrements on pipeline-head exit; simultaneous inc and dec leaves it unchanged.
REQ-026 A valid head arriving without norm_done_i SHALL set sticky err flag, visible via busy_o remaining high until reset, and SHALL not push.

Reset
REQ-027 rst_i asserted SHALL immediately force state IDLE, pipeline valids 0, FIFO empty, counters 0, RR pointer to NUM_REQ-1 (so requester 0 wins first), err 0.
REQ-028 Reset outputs: busy_o=0, norm_init_o=0, req_ready_o=0, rsp_valid_o=0, all data outputs 0.
REQ-029 Reset mid-operation SHALL drop all in-flight and buffered results without emitting them.

Structure
REQ-030 Package ame_norm_pkg SHALL hold the FSM state enum, the tag entry struct and default parameter constants.
REQ-031 The result FIFO SHALL be a sub-module ame_norm_fifo (depth, width parameters, count output).
REQ-032 The normalizer is instantiated outside this block; bench uses a NORM_LAT-cycle model returning data<<shift.

Verification
REQ-033 Single requester: enable=1, req0 data=0x1, shift=4 -> rsp_id=0, rsp_data=0x10, NORM_LAT+1 cycles after transfer.
REQ-034 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, responses in the same id order.
REQ-035 rsp_ready_i=0, all valid -> exactly RSP_DEPTH=4 grants, then req_ready_o=0 until one pop, then one grant.
REQ-036 enable_i dropped with 2 in flight -> DRAIN, both results pushed, then IDLE, norm_init_o=0, busy_o=0.
REQ-037 rst_i asserted with 3 results buffered -> rsp_valid_o=0 immediately, nothing emitted after release.
REQ-038 Model suppresses one done -> err set, busy_o stays 1, that result absent, later results unaffected.
